// File: rtl/mem_pkg.sv
`default_nettype none
// =====================================================================
// mem_pkg : size codes, FSM encoding and byte-enable constants
// Rev 1.0
// =====================================================================
package mem_pkg;

  // Access size codes; 2'b11 is handled as a word everywhere
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// =====================================================================
// mem_align : combinational lane steering (byte enables, store
//             replication, load extraction/extension, misalign flag)
// Rev 1.0
// =====================================================================
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata_ext,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_be        = BE_WORD;
    o_wdata_rep = i_wdata;
    o_rdata_ext = i_rdata;
    o_misalign  = (i_addr_lo != 2'b00);
    case (i_size)
      SZ_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_rdata_ext = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
        o_misalign  = 1'b0;
      end
      SZ_HALF: begin
        // addr[0] is dropped here; only the trap logic looks at it
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_rdata_ext = {{16{w_half[15] & ~i_unsigned}}, w_half};
        o_misalign  = i_addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// =====================================================================
// mem_access_unit : MEM-stage data-memory req/ack engine with stall.
// Optional misaligned-access trap: MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
// Rev 1.0
// =====================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       md_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [31:0]       dmem_rdata_i
);

`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
  localparam bit c_TRAP_EN = 1'b1;
`else
  localparam bit c_TRAP_EN = 1'b0;
`endif

  logic [1:0]        r_state;
  logic [31:0]       r_md;
  logic              r_misalign;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;

  logic              w_access;
  logic              w_trap;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_rep;
  logic [31:0]       w_rdata_ext;
  logic              w_misalign;

  mem_align u_align (
    .i_size      (size_i),
    .i_unsigned  (unsigned_i),
    .i_addr_lo   (addr_i[1:0]),
    .i_wdata     (wdata_i),
    .i_rdata     (dmem_rdata_i),
    .o_be        (w_be),
    .o_wdata_rep (w_wdata_rep),
    .o_rdata_ext (w_rdata_ext),
    .o_misalign  (w_misalign)
  );

  assign w_access = mem_read_i | mem_write_i;
  assign w_trap   = c_TRAP_EN & w_misalign;
  // DONE is the single cycle in which the pipeline is released
  assign stall_o  = w_access & (r_state != ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_md       <= 32'h0;
      r_misalign <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_trap) begin
              r_misalign <= 1'b1;
              if (!mem_write_i) r_md <= 32'h0;
              r_state    <= ST_DONE;
            end else begin
              r_req   <= 1'b1;
              r_we    <= mem_write_i;
              r_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
              r_be    <= w_be;
              r_wdata <= w_wdata_rep;
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // Inputs are frozen by stall_o, so they still describe this access
          if (dmem_ack_i) begin
            r_req   <= 1'b0;
            if (!mem_write_i) r_md <= w_rdata_ext;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_misalign <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign md_o         = r_md;
  assign misalign_o   = c_TRAP_EN & r_misalign;
  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access engine between the EX/MEM register and the MEM/WB register.
- Takes the EX/MEM load/store controls, address and store data. Runs a req/ack handshake with a variable-latency data memory and performs byte/half/word lane steering.
- Returns the extended load word that feeds MEM/WB's memory-data input.
- Stalls the pipeline until each access completes.

Parameters:
- ADDR_W, 32, data address width in bits; dmem_addr is word-aligned.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (low = reset, sampled on posedge clk)
- mem_read_i  in  1  load request from EX/MEM
- mem_write_i  in  1  store request from EX/MEM; read and write both high is treated as a write
- size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- unsigned_i  in  1  1 = zero-extend loads, 0 = sign-extend
- addr_i  in  ADDR_W  byte address (EX/MEM ALU result)
- wdata_i  in  32  store data (rt value)
- md_o  out  32  load result to MEM/WB; held until the next completed load
- stall_o  out  1  freeze IF..EX/MEM and the MEM/WB load enable
- misalign_o  out  1  misaligned-access pulse (optional feature)
- dmem_req_o  out  1  memory request, registered
- dmem_we_o  out  1  write enable, registered
- dmem_addr_o  out  ADDR_W  {addr_i[ADDR_W-1:2],2'b00}, registered
- dmem_be_o  out  4  byte enables, registered
- dmem_wdata_o  out  32  lane-replicated store data, registered
- dmem_ack_i  in  1  memory done; rdata valid in the same cycle for reads
- dmem_rdata_i  in  32  read word

Behaviour:
- Reset (rst low at a clock edge): state IDLE. md_o, dmem_addr_o, dmem_wdata_o = 0; dmem_req_o, dmem_we_o, dmem_be_o, misalign_o = 0.
- Reset has priority in every state. Reset during BUSY drops dmem_req_o on the next edge; the access is abandoned.
- Let access = mem_read_i | mem_write_i.
- stall_o is combinational: stall_o = access & (state != DONE).
- Upstream holds all inputs stable while stall_o is high.
- FSM states: IDLE, BUSY, DONE.
  - IDLE & access: register the address, be, wdata and we, and set dmem_req_o = 1. Next state BUSY.
  - IDLE & !access: stay in IDLE; no request.
  - BUSY & !dmem_ack_i: hold all dmem_* outputs unchanged.
  - BUSY & dmem_ack_i: dmem_req_o = 0. If the access is a load, md_o <= extended lane of dmem_rdata_i. Next state DONE.
  - DONE: stall_o = 0, so the pipeline advances at the end of this cycle. Next state IDLE.
- Timing:
  - Minimum occupancy is 3 cycles (zero-wait memory acks in the first BUSY cycle).
  - stall_o is high for 2 + wait cycles.
  - A new access is accepted in the IDLE cycle after DONE.
- dmem_ack_i in IDLE or DONE is ignored.
- Stores never change md_o.
- Byte enables: byte 4'b0001 << addr[1:0]; half 4'b0011 << {addr[1],1'b0}; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load data:
  - byte: lane addr[1:0] (rdata[8*a+7:8*a]), 8 -> 32 extension.
  - half: lane addr[1], 16 -> 32 extension.
  - word: as is.
  - Sign extension unless unsigned_i is 1.

Optional Feature:
- Macro: MEM_ACCESS_UNIT_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no dmem request.
  - The FSM goes IDLE -> DONE directly, so stall_o is high 1 cycle.
  - misalign_o = 1 during that DONE cycle only.
  - A misaligned load sets md_o = 0; a misaligned store writes nothing.
- Undefined:
  - The ignored low address bits are dropped: half uses addr[1], word uses addr[ADDR_W-1:2].
  - misalign_o is tied 0.

Decomposition:
- Package mem_pkg: size codes (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encoding, BE_WORD = 4'hF.
- Sub-module mem_align: purely combinational. Computes be, store replication and load extraction/extension from size, unsigned and addr[1:0]; also computes the misalign flag.
- mem_access_unit holds the FSM and registers.

Test Plan:
- Word store, ack after 3 wait cycles, addr = 0x104, wdata = 0xDEADBEEF -> dmem_be_o = F, dmem_addr_o = 0x104; dmem_req_o high for 4 cycles; stall_o high for 5 cycles, then low in DONE.
- Signed byte load, addr = 0x203, rdata = 0x80FF1234, zero-wait -> md_o = 0xFFFFFF80; stall_o high for exactly 2 cycles.
- Unsigned half load, addr = 0x202, rdata = 0x80FF1234 -> md_o = 0x000080FF. Signed half load, addr = 0x200 -> md_o = 0x00001234.
- Byte store, addr = 0x3, wdata = 0x000000AB -> dmem_be_o = 4'b1000, dmem_wdata_o = 0xABABABAB; md_o unchanged.
- rst driven low in the 2nd BUSY cycle, then a spurious dmem_ack_i while idle -> req drops next edge, state IDLE, md_o = 0, no DONE cycle.
- With MEM_ACCESS_UNIT_MISALIGN_TRAP_EN, word load at addr = 0x102 -> no dmem_req_o, misalign_o pulses for 1 cycle, md_o = 0, stall_o high for 1 cycle.
